multicycle_alu: RTL
===================

# multicycle_alu

Parametrised sequential ALU replacing the purely combinational 32-bit ALU in the datapath. It performs single-cycle logic, arithmetic and shift/rotate operations, plus iterative signed multiply (WIDTH cycles) and signed divide (WIDTH+1 cycles), behind a start/busy/done handshake. It sits between the A/B operand registers and the Z (HI/LO) register pair, and is driven by the control unit.

## Interface
- WIDTH, 32: operand width; C is 2*WIDTH; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0]; derived, never overridden.

- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled only when busy=0.
- opcode  in  5  operation select; encodings in alu_pkg.
- A  in  WIDTH  operand A (dividend, multiplicand, shift source).
- B  in  WIDTH  operand B (divisor, multiplier, shift amount).
- C  out  2*WIDTH  result register; HI = C[2W-1:W], LO = C[W-1:0].
- busy  out  1  high while a multi-cycle operation is in flight.
- done  out  1  one-cycle pulse: C updated this cycle.
- div_zero  out  1  valid with done; high when the last op was div with B=0.

## Operation
- States: IDLE, MUL, DIV, FIX. busy = (state != IDLE).
- IDLE, start=1, single-cycle op (add, sub, and, or, xor, nor, not, neg, shl, shr, shra, rol, ror): C written at that edge and done=1 for the next cycle. LO = result; HI = {WIDTH{LO[W-1]}}.
- Shifts and rotates use amount B[SHW-1:0]. shra replicates A[W-1]. Amount 0 returns A.
- nop or an undefined opcode: done pulses after 1 cycle, C unchanged, div_zero=0.
- mul: A and B latched, go to MUL. Radix-2 Booth, one step per cycle, WIDTH steps. The final step writes the full signed 2W-bit product to C, goes to IDLE and pulses done.
- div, B≠0: operands latched, go to DIV. Non-restoring on |A| and |B|, WIDTH steps, then FIX applies remainder restore and sign correction.
  - Quotient truncates toward zero. Remainder takes the sign of A.
  - LO = quotient, HI = remainder.
  - MIN / -1 gives LO = MIN (wraps), HI = 0.
- div, B=0: no iteration. After 1 cycle C = {A, {WIDTH{1'b1}}}, div_zero=1, done pulses.
- div_zero holds until the next done.
- start while busy=1 is ignored, with no queuing. Operand changes after launch do not affect the result.
- C holds its value between completions.

## Timing
- Reset (clear=1, asynchronous): state=IDLE, C=0, busy=0, done=0, div_zero=0, step counter=0. Takes effect mid-operation with no completion pulse.
- start accepted at edge k:
  - single-cycle op / nop / div-by-zero: done high in cycle k+1.
  - mul: busy high for cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1 (busy already 0).
  - div: busy high for cycles k+1..k+WIDTH+1; done high in cycle k+WIDTH+2.
- start may be reasserted in the same cycle done is high. It is accepted (back-to-back issue).
- The step counter ends exactly at WIDTH-1; there is no wrap.

## Structure
- Package alu_pkg holds:
  - opcode localparams: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, xor 01101, nor 01110, div 01111, mul 10000, neg 10001, not 10010, nop 11010.
  - state encodings.
- Sub-module alu_shifter(WIDTH): combinational barrel shifter/rotator covering shl/shr/shra/rol/ror.
- The Booth and non-restoring datapaths share one WIDTH+1-bit adder/subtractor inside multicycle_alu.

## Test plan
- add, A=0x7FFFFFFF, B=1 -> C=0xFFFFFFFF_80000000, done in cycle k+1, busy never high.
- mul, A=0xFFFFFFFD (-3), B=7 -> C=0xFFFFFFFF_FFFFFFEB, busy high for exactly 32 cycles, done in cycle k+33. Also A=B=0x80000000 -> C=0x40000000_00000000.
- div, A=-7, B=2 -> C=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3), done in cycle k+34. Also A=0x80000000, B=-1 -> C=0x00000000_80000000.
- div, A=5, B=0 -> C=0x00000005_FFFFFFFF, div_zero=1, done in cycle k+1.
- ror, A=1, B=33 (amount 1) -> C=0xFFFFFFFF_80000000. shra, A=0x80000000, B=4 -> LO=0xF8000000.
- mul started, clear pulsed at cycle k+10 -> C=0, busy=0, done=0 immediately, with no later done. A start during busy is ignored. A start during done is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings, FSM states and decode helper for multicycle_alu
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_ror  = 5'b00111;
  localparam logic [4:0] c_op_rol  = 5'b01000;
  localparam logic [4:0] c_op_shr  = 5'b01001;
  localparam logic [4:0] c_op_shra = 5'b01010;
  localparam logic [4:0] c_op_shl  = 5'b01011;
  localparam logic [4:0] c_op_xor  = 5'b01101;
  localparam logic [4:0] c_op_nor  = 5'b01110;
  localparam logic [4:0] c_op_div  = 5'b01111;
  localparam logic [4:0] c_op_mul  = 5'b10000;
  localparam logic [4:0] c_op_neg  = 5'b10001;
  localparam logic [4:0] c_op_not  = 5'b10010;
  localparam logic [4:0] c_op_nop  = 5'b11010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  function automatic logic is_single_op(input logic [4:0] op);
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_nor, c_op_not,
      c_op_neg, c_op_shl, c_op_shr, c_op_shra, c_op_rol, c_op_ror:
        is_single_op = 1'b1;
      default:
        is_single_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_shifter
// Brief    : Combinational barrel shifter / rotator (shl, shr, shra, rol, ror)
// Revision : 1.0
// ============================================================================
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [4:0]               op,
  output logic [WIDTH-1:0]         y
);

  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  // ~amt equals WIDTH-1-amt, so the extra shift by one yields WIDTH-amt and
  // an amount of 0 contributes nothing from the wrapped side.
  assign w_rol = (a << amt) | ((a >> (~amt)) >> 1);
  assign w_ror = (a >> amt) | ((a << (~amt)) << 1);

  always_comb begin
    y = '0;
    case (op)
      c_op_shl:  y = a << amt;
      c_op_shr:  y = a >> amt;
      c_op_shra: y = $signed(a) >>> amt;
      c_op_rol:  y = w_rol;
      c_op_ror:  y = w_ror;
      default:   y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Sequential ALU: single-cycle ops plus Booth multiply and
//            non-restoring divide behind a start/busy/done handshake
// Revision : 1.0
// ============================================================================
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);

  state_t               r_state, w_state_n;
  logic [2*WIDTH-1:0]   r_c, w_c_n;
  logic                 r_done, w_done_n;
  logic                 r_div_zero, w_dz_n;
  logic [SHW-1:0]       r_count, w_count_n;
  logic [WIDTH:0]       r_acc, w_acc_n;     // Booth accumulator / partial remainder
  logic [WIDTH-1:0]     r_q, w_q_n;         // multiplier / quotient
  logic                 r_qm1, w_qm1_n;
  logic [WIDTH-1:0]     r_m, w_m_n;         // multiplicand / |divisor|
  logic                 r_neg_q, w_neg_q_n;
  logic                 r_neg_r, w_neg_r_n;

  logic [WIDTH-1:0]     w_shift;
  logic [WIDTH-1:0]     w_single;
  logic                 w_single_ok;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_add_a, w_add_b, w_sum, w_booth;
  logic                 w_add_sub;
  logic [WIDTH:0]       w_mul_acc;
  logic [WIDTH-1:0]     w_mul_q;
  logic [WIDTH-1:0]     w_rem;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a   (A),
    .amt (B[SHW-1:0]),
    .op  (opcode),
    .y   (w_shift)
  );

  assign w_single_ok = is_single_op(opcode);

  always_comb begin
    w_single = '0;
    case (opcode)
      c_op_add: w_single = A + B;
      c_op_sub: w_single = A - B;
      c_op_and: w_single = A & B;
      c_op_or:  w_single = A | B;
      c_op_xor: w_single = A ^ B;
      c_op_nor: w_single = ~(A | B);
      c_op_not: w_single = ~A;
      c_op_neg: w_single = -A;
      default:  w_single = w_shift;
    endcase
  end

  assign w_abs_a = A[WIDTH-1] ? -A : A;
  assign w_abs_b = B[WIDTH-1] ? -B : B;

  // Single adder/subtractor shared by Booth steps, divide steps and the
  // final remainder restore.
  always_comb begin
    w_add_a   = r_acc;
    w_add_b   = {1'b0, r_m};
    w_add_sub = 1'b0;
    case (r_state)
      S_MUL: begin
        w_add_b   = {r_m[WIDTH-1], r_m};
        w_add_sub = r_q[0] & ~r_qm1;
      end
      S_DIV: begin
        w_add_a   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_add_sub = ~r_acc[WIDTH];
      end
      default: ;
    endcase
  end

  assign w_sum     = w_add_sub ? (w_add_a - w_add_b) : (w_add_a + w_add_b);
  assign w_booth   = (r_q[0] ^ r_qm1) ? w_sum : r_acc;
  assign w_mul_acc = {w_booth[WIDTH], w_booth[WIDTH:1]};
  assign w_mul_q   = {w_booth[0], r_q[WIDTH-1:1]};
  assign w_rem     = r_acc[WIDTH] ? w_sum[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_comb begin
    w_state_n = r_state;
    w_c_n     = r_c;
    w_done_n  = 1'b0;
    w_dz_n    = r_div_zero;
    w_count_n = r_count;
    w_acc_n   = r_acc;
    w_q_n     = r_q;
    w_qm1_n   = r_qm1;
    w_m_n     = r_m;
    w_neg_q_n = r_neg_q;
    w_neg_r_n = r_neg_r;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (opcode == c_op_mul) begin
            w_count_n = '0;
            w_acc_n   = '0;
            w_m_n     = A;
            w_q_n     = B;
            w_qm1_n   = 1'b0;
            w_state_n = S_MUL;
          end else if (opcode == c_op_div && B != '0) begin
            w_count_n = '0;
            w_acc_n   = '0;
            w_m_n     = w_abs_b;
            w_q_n     = w_abs_a;
            w_neg_q_n = A[WIDTH-1] ^ B[WIDTH-1];
            w_neg_r_n = A[WIDTH-1];
            w_state_n = S_DIV;
          end else begin
            w_done_n = 1'b1;
            w_dz_n   = 1'b0;
            if (opcode == c_op_div) begin
              w_c_n  = {A, {WIDTH{1'b1}}};
              w_dz_n = 1'b1;
            end else if (w_single_ok) begin
              w_c_n = {{WIDTH{w_single[WIDTH-1]}}, w_single};
            end
          end
        end
      end
      S_MUL: begin
        w_acc_n = w_mul_acc;
        w_q_n   = w_mul_q;
        w_qm1_n = r_q[0];
        if (r_count == c_last) begin
          w_c_n     = {w_mul_acc[WIDTH-1:0], w_mul_q};
          w_done_n  = 1'b1;
          w_dz_n    = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_count_n = r_count + 1'b1;
        end
      end
      S_DIV: begin
        w_acc_n = w_sum;
        w_q_n   = {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
        if (r_count == c_last) begin
          w_state_n = S_FIX;
        end else begin
          w_count_n = r_count + 1'b1;
        end
      end
      S_FIX: begin
        w_c_n     = {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -r_q : r_q)};
        w_done_n  = 1'b1;
        w_dz_n    = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_c        <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_count    <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_m        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      r_c        <= w_c_n;
      r_done     <= w_done_n;
      r_div_zero <= w_dz_n;
      r_count    <= w_count_n;
      r_acc      <= w_acc_n;
      r_q        <= w_q_n;
      r_qm1      <= w_qm1_n;
      r_m        <= w_m_n;
      r_neg_q    <= w_neg_q_n;
      r_neg_r    <= w_neg_r_n;
    end
  end

  assign C        = r_c;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule
`default_nettype wire
